game_2048_move_engine: RTL and testbench

//  Board-state engine for 2048: owns the 4x4 board and applies one move per request (slide/merge one line per cycle).

---
 rtl/game_2048_pkg.sv | 34 +++
 rtl/game_2048_line_merge.sv | 54 +++++
 rtl/game_2048_move_engine.sv | 240 ++++++++++++++++++++++++
 tb/tb_game_2048_move_engine.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_2048_pkg.sv
// Shared definitions for the 2048 board engine: direction codes, tile geometry,
// FSM state type and the line-to-cell index lookup used by SLIDE.
package game_2048_pkg;

    localparam int unsigned TILE_W = 4;
    localparam int unsigned CELLS  = 16;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_LEFT  = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_SLIDE,
        ST_SPAWN,
        ST_CHECK
    } state_e;

    // Cell index (row*4+col) of element 'pos' of line 'line' when sliding in 'dir'.
    // Position 0 is the cell tiles are pushed toward.
    function automatic logic [3:0] line_cell(input logic [1:0] dir,
                                             input logic [1:0] line,
                                             input logic [1:0] pos);
        case (dir)
            DIR_UP:   return {pos, line};
            DIR_LEFT: return {line, pos};
            DIR_DOWN: return {~pos, line};
            default:  return {line, ~pos};
        endcase
    endfunction

endpackage

// File: rtl/game_2048_line_merge.sv
// Combinational slide/merge of one 4-tile line toward element 0.
// Reports whether the line changed and the score earned by its merges.
module game_2048_line_merge
    import game_2048_pkg::*;
(
    input  logic [4*TILE_W-1:0] line_i,
    output logic [4*TILE_W-1:0] line_o,
    output logic                changed_o,
    output logic [17:0]         score_delta_o
);

    // Compacted tiles; slot 4 stays empty so the last tile never finds a partner.
    logic [TILE_W-1:0] packed_t [5];
    logic [2:0]        n;
    logic [2:0]        o;
    logic              skip;

    // Compact non-zero tiles, then merge equal neighbours once, left to right.
    always_comb begin
        for (int unsigned k = 0; k < 5; k++) begin
            packed_t[k] = '0;
        end
        n             = '0;
        o             = '0;
        skip          = 1'b0;
        line_o        = '0;
        score_delta_o = '0;

        for (int unsigned k = 0; k < 4; k++) begin
            if (line_i[k*TILE_W +: TILE_W] != '0) begin
                packed_t[n] = line_i[k*TILE_W +: TILE_W];
                n           = n + 3'd1;
            end
        end

        for (int unsigned k = 0; k < 4; k++) begin
            if (skip) begin
                skip = 1'b0;
            end else if (packed_t[k] != '0) begin
                if (packed_t[k+1] == packed_t[k]) begin
                    line_o[o*TILE_W +: TILE_W] = (packed_t[k] == '1) ? '1 : packed_t[k] + 4'd1;
                    score_delta_o = score_delta_o + (18'd1 << (5'(packed_t[k]) + 5'd1));
                    skip = 1'b1;
                end else begin
                    line_o[o*TILE_W +: TILE_W] = packed_t[k];
                end
                o = o + 3'd1;
            end
        end

        changed_o = (line_o != line_i);
    end

endmodule

// File: rtl/game_2048_move_engine.sv
// 2048 board engine: owns the 4x4 board, applies one move per request (one line
// per cycle), spawns a tile after effective moves and evaluates won/game_over.
// Optional single-level undo is compiled in with `define GAME2048_UNDO_EN.
module game_2048_move_engine
    import game_2048_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int unsigned SCORE_W   = 20,
    parameter int unsigned WIN_EXP   = 11
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               move_valid,
    input  logic [1:0]         move_dir,
    input  logic               load_valid,
    input  logic [63:0]        load_board,
    input  logic               undo_valid,
    output logic [63:0]        board_state,
    output logic [SCORE_W-1:0] score,
    output logic               busy,
    output logic               won,
    output logic               game_over
);

    localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0) ? 16'hACE1 : LFSR_SEED;
    localparam int unsigned SUM_W    = SCORE_W + 18;

    state_e               state_q, state_d;
    logic [63:0]          board_q, board_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic                 won_q, won_d;
    logic                 go_q, go_d;
    logic [15:0]          lfsr_q, lfsr_d;
    logic [1:0]           dir_q, dir_d;
    logic [1:0]           line_q, line_d;
    logic                 moved_q, moved_d;
    logic [3:0]           scan_idx_q, scan_idx_d;
    logic [3:0]           scan_cnt_q, scan_cnt_d;
    logic [1:0]           spawn_left_q, spawn_left_d;
`ifdef GAME2048_UNDO_EN
    logic [63:0]          snap_board_q, snap_board_d;
    logic [SCORE_W-1:0]   snap_score_q, snap_score_d;
    logic                 snap_valid_q, snap_valid_d;
`else
    logic                 unused_undo;
    assign unused_undo = undo_valid;
`endif

    logic [4*TILE_W-1:0]  mline_in, mline_out;
    logic                 mchanged;
    logic [17:0]          mdelta;
    logic [SUM_W-1:0]     score_sum;
    logic [SCORE_W-1:0]   score_sat;
    logic                 any_win, any_empty, any_pair;
    logic                 spawn_done;

    game_2048_line_merge u_merge (
        .line_i        (mline_in),
        .line_o        (mline_out),
        .changed_o     (mchanged),
        .score_delta_o (mdelta)
    );

    assign board_state = board_q;
    assign score       = score_q;
    assign busy        = (state_q != ST_IDLE);
    assign won         = won_q;
    assign game_over   = go_q;

    assign lfsr_d    = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    assign score_sum = SUM_W'(score_q) + SUM_W'(mdelta);
    assign score_sat = (score_sum > SUM_W'({SCORE_W{1'b1}})) ? '1 : score_sum[SCORE_W-1:0];

    // Gather the line selected by dir/line_q into merge order.
    always_comb begin
        mline_in = '0;
        for (int unsigned p = 0; p < 4; p++) begin
            mline_in[p*TILE_W +: TILE_W] = board_q[{line_cell(dir_q, line_q, 2'(p)), 2'b00} +: TILE_W];
        end
    end

    // Board-wide win / empty / mergeable-neighbour flags for CHECK.
    always_comb begin
        any_win   = 1'b0;
        any_empty = 1'b0;
        any_pair  = 1'b0;
        for (int unsigned i = 0; i < CELLS; i++) begin
            if (board_q[i*TILE_W +: TILE_W] == '0) any_empty = 1'b1;
            if (32'(board_q[i*TILE_W +: TILE_W]) >= WIN_EXP) any_win = 1'b1;
            if ((i % 4 != 3) && (board_q[i*TILE_W +: TILE_W] == board_q[((i+1)%CELLS)*TILE_W +: TILE_W]))
                any_pair = 1'b1;
            if ((i < 12) && (board_q[i*TILE_W +: TILE_W] == board_q[((i+4)%CELLS)*TILE_W +: TILE_W]))
                any_pair = 1'b1;
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_d      = state_q;
        board_d      = board_q;
        score_d      = score_q;
        won_d        = won_q;
        go_d         = go_q;
        dir_d        = dir_q;
        line_d       = line_q;
        moved_d      = moved_q;
        scan_idx_d   = scan_idx_q;
        scan_cnt_d   = scan_cnt_q;
        spawn_left_d = spawn_left_q;
        spawn_done   = 1'b0;
`ifdef GAME2048_UNDO_EN
        snap_board_d = snap_board_q;
        snap_score_d = snap_score_q;
        snap_valid_d = snap_valid_q;
`endif
        case (state_q)
            ST_INIT: begin
                spawn_left_d = 2'd2;
                scan_idx_d   = lfsr_q[3:0];
                scan_cnt_d   = '0;
                state_d      = ST_SPAWN;
            end
            ST_IDLE: begin
                if (load_valid) begin
                    board_d = load_board;
                    won_d   = 1'b0;
                    go_d    = 1'b0;
                    state_d = ST_CHECK;
`ifdef GAME2048_UNDO_EN
                end else if (undo_valid) begin
                    if (snap_valid_q) begin
                        board_d      = snap_board_q;
                        score_d      = snap_score_q;
                        go_d         = 1'b0;
                        snap_valid_d = 1'b0;
                        state_d      = ST_CHECK;
                    end
`endif
                end else if (move_valid && !go_q) begin
                    dir_d   = move_dir;
                    line_d  = '0;
                    moved_d = 1'b0;
                    state_d = ST_SLIDE;
`ifdef GAME2048_UNDO_EN
                    snap_board_d = board_q;
                    snap_score_d = score_q;
                    snap_valid_d = 1'b1;
`endif
                end
            end
            ST_SLIDE: begin
                for (int unsigned p = 0; p < 4; p++) begin
                    board_d[{line_cell(dir_q, line_q, 2'(p)), 2'b00} +: TILE_W] = mline_out[p*TILE_W +: TILE_W];
                end
                score_d = score_sat;
                moved_d = moved_q | mchanged;
                line_d  = line_q + 2'd1;
                if (line_q == 2'd3) begin
                    if (moved_q | mchanged) begin
                        spawn_left_d = 2'd1;
                        scan_idx_d   = lfsr_q[3:0];
                        scan_cnt_d   = '0;
                        state_d      = ST_SPAWN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_SPAWN: begin
                if (board_q[{scan_idx_q, 2'b00} +: TILE_W] == '0) begin
                    board_d[{scan_idx_q, 2'b00} +: TILE_W] = (lfsr_q[7:4] == 4'd0) ? 4'd2 : 4'd1;
                    spawn_done = 1'b1;
                end else if (scan_cnt_q == 4'd15) begin
                    spawn_done = 1'b1;
                end else begin
                    scan_idx_d = scan_idx_q + 4'd1;
                    scan_cnt_d = scan_cnt_q + 4'd1;
                end
                if (spawn_done) begin
                    if (spawn_left_q > 2'd1) begin
                        spawn_left_d = spawn_left_q - 2'd1;
                        scan_idx_d   = lfsr_q[3:0];
                        scan_cnt_d   = '0;
                    end else begin
                        spawn_left_d = '0;
                        state_d      = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                won_d   = won_q | any_win;
                go_d    = go_q | (!any_empty && !any_pair);
                state_d = ST_IDLE;
            end
            default: state_d = ST_INIT;
        endcase
    end

    // State register; reset discards any move in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_INIT;
            board_q      <= '0;
            score_q      <= '0;
            won_q        <= 1'b0;
            go_q         <= 1'b0;
            lfsr_q       <= SEED_EFF;
            dir_q        <= '0;
            line_q       <= '0;
            moved_q      <= 1'b0;
            scan_idx_q   <= '0;
            scan_cnt_q   <= '0;
            spawn_left_q <= '0;
`ifdef GAME2048_UNDO_EN
            snap_board_q <= '0;
            snap_score_q <= '0;
            snap_valid_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            board_q      <= board_d;
            score_q      <= score_d;
            won_q        <= won_d;
            go_q         <= go_d;
            lfsr_q       <= lfsr_d;
            dir_q        <= dir_d;
            line_q       <= line_d;
            moved_q      <= moved_d;
            scan_idx_q   <= scan_idx_d;
            scan_cnt_q   <= scan_cnt_d;
            spawn_left_q <= spawn_left_d;
`ifdef GAME2048_UNDO_EN
            snap_board_q <= snap_board_d;
            snap_score_q <= snap_score_d;
            snap_valid_q <= snap_valid_d;
`endif
        end
    end

endmodule

// File: tb/tb_game_2048_move_engine.sv
// Self-checking bench for game_2048_move_engine: directed and randomized loads and
// moves compared with a queue-based model of the 2048 slide/merge rules.
module tb_game_2048_move_engine;

    localparam longint SCORE_MAX = 64'd1048575;

    logic        clk = 1'b0;
    logic        reset, move_valid, load_valid, undo_valid;
    logic [1:0]  move_dir;
    logic [63:0] load_board;
    logic [63:0] board_state;
    logic [19:0] score;
    logic        busy, won, game_over;

    int     n_cmp = 0;
    int     n_bad = 0;
    logic [63:0] cur_board;
    bit     cur_won, cur_go;
    longint exp_score;

    game_2048_move_engine #(.LFSR_SEED(16'hACE1), .SCORE_W(20), .WIN_EXP(11)) dut (
        .clk         (clk),
        .reset       (reset),
        .move_valid  (move_valid),
        .move_dir    (move_dir),
        .load_valid  (load_valid),
        .load_board  (load_board),
        .undo_valid  (undo_valid),
        .board_state (board_state),
        .score       (score),
        .busy        (busy),
        .won         (won),
        .game_over   (game_over)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int max);
        int i;
        i = 0;
        while (busy && i < max) begin
            tick();
            i++;
        end
        chk("idle_timeout", {63'd0, busy}, 64'd0);
    endtask

    function automatic int get(input logic [63:0] b, input int r, input int c);
        return int'(b[(r*4+c)*4 +: 4]);
    endfunction

    function automatic logic [63:0] put(input logic [63:0] b, input int r, input int c, input int v);
        b[(r*4+c)*4 +: 4] = 4'(v);
        return b;
    endfunction

    // Element p of line l when tiles slide toward p=0 in direction dir.
    function automatic void cell_rc(input int dir, input int l, input int p, output int r, output int c);
        case (dir)
            0:       begin r = p;     c = l;     end
            1:       begin r = l;     c = p;     end
            2:       begin r = 3 - p; c = l;     end
            default: begin r = l;     c = 3 - p; end
        endcase
    endfunction

    function automatic void model_move(input logic [63:0] b, input int dir,
                                       output logic [63:0] nb, output longint delta);
        int q[$];
        int o[$];
        int r, c, a;
        nb = '0;
        delta = 0;
        for (int l = 0; l < 4; l++) begin
            q.delete();
            o.delete();
            for (int p = 0; p < 4; p++) begin
                cell_rc(dir, l, p, r, c);
                if (get(b, r, c) != 0) q.push_back(get(b, r, c));
            end
            while (q.size() > 0) begin
                a = q.pop_front();
                if (q.size() > 0 && q[0] == a) begin
                    void'(q.pop_front());
                    o.push_back((a == 15) ? 15 : a + 1);
                    delta += longint'(1) << (a + 1);
                end else begin
                    o.push_back(a);
                end
            end
            for (int p = 0; p < 4; p++) begin
                cell_rc(dir, l, p, r, c);
                nb = put(nb, r, c, (p < o.size()) ? o[p] : 0);
            end
        end
    endfunction

    function automatic void model_flags(input logic [63:0] b, output bit w, output bit g, output int empties);
        bit pair;
        w = 0; pair = 0; empties = 0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                if (get(b, r, c) >= 11) w = 1;
                if (get(b, r, c) == 0) empties++;
                if (c < 3 && get(b, r, c) == get(b, r, c + 1)) pair = 1;
                if (r < 3 && get(b, r, c) == get(b, r + 1, c)) pair = 1;
            end
        g = (empties == 0) && !pair;
    endfunction

    task automatic do_reset();
        int nz, bad;
        reset = 1'b1;
        repeat (2) tick();
        chk("rst_board", board_state, 64'd0);
        chk("rst_score", 64'(score), 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd1);
        chk("rst_flags", {62'd0, won, game_over}, 64'd0);
        reset = 1'b0;
        wait_idle(40);
        nz = 0; bad = 0;
        for (int i = 0; i < 16; i++) begin
            if (board_state[i*4 +: 4] != 4'd0) begin
                nz++;
                if (board_state[i*4 +: 4] > 4'd2) bad++;
            end
        end
        chk("init_tiles", 64'(nz), 64'd2);
        chk("init_vals", 64'(bad), 64'd0);
        chk("init_score", 64'(score), 64'd0);
        exp_score = 0;
    endtask

    task automatic do_load(input logic [63:0] b);
        bit w, g;
        int e;
        load_board = b;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        wait_idle(10);
        model_flags(b, w, g, e);
        chk("load_board", board_state, b);
        chk("load_won", {63'd0, won}, {63'd0, w});
        chk("load_over", {63'd0, game_over}, {63'd0, g});
        chk("load_score", 64'(score), 64'(exp_score));
        cur_board = b;
        cur_won = w;
        cur_go = g;
    endtask

    task automatic do_move(input int dir);
        logic [63:0] nb, act;
        longint d;
        int diff, bad, e;
        bit w, g;
        model_move(cur_board, dir, nb, d);
        move_dir = 2'(dir);
        move_valid = 1'b1;
        tick();
        move_valid = 1'b0;
        chk("busy_T1", {63'd0, busy}, 64'd1);
        if (nb == cur_board) begin
            repeat (3) tick();
            chk("busy_T4", {63'd0, busy}, 64'd1);
            tick();
            chk("busy_T5", {63'd0, busy}, 64'd0);
            chk("nomove_board", board_state, cur_board);
            chk("nomove_score", 64'(score), 64'(exp_score));
        end else begin
            wait_idle(40);
            exp_score = (exp_score + d > SCORE_MAX) ? SCORE_MAX : exp_score + d;
            act = board_state;
            diff = 0; bad = 0;
            for (int i = 0; i < 16; i++) begin
                if (act[i*4 +: 4] != nb[i*4 +: 4]) begin
                    diff++;
                    if (nb[i*4 +: 4] != 4'd0 || act[i*4 +: 4] == 4'd0 || act[i*4 +: 4] > 4'd2) bad++;
                end
            end
            chk("move_new_tiles", 64'(diff), 64'd1);
            chk("move_bad_cells", 64'(bad), 64'd0);
            chk("move_score", 64'(score), 64'(exp_score));
            model_flags(nb, w, g, e);
            chk("move_won", {63'd0, won}, {63'd0, (cur_won | w)});
            if (e >= 2) chk("move_over", {63'd0, game_over}, 64'd0);
        end
    endtask

    task automatic try_dropped_moves(input logic [63:0] b);
        for (int d = 0; d < 4; d++) begin
            move_dir = 2'(d);
            move_valid = 1'b1;
            tick();
            move_valid = 1'b0;
            chk("over_busy", {63'd0, busy}, 64'd0);
            tick();
            chk("over_board", board_state, b);
        end
    endtask

    function automatic logic [63:0] rand_board();
        logic [63:0] b;
        int mode;
        b = '0;
        mode = int'($urandom_range(0, 3));
        for (int i = 0; i < 16; i++) begin
            if (mode == 0) b[i*4 +: 4] = 4'($urandom_range(1, 3));
            else if ($urandom_range(0, 1) == 0) b[i*4 +: 4] = 4'($urandom_range(1, 11));
        end
        return b;
    endfunction

    initial begin
        logic [63:0] b, cb;
        longint pre_score;
        reset = 1'b1; move_valid = 1'b0; load_valid = 1'b0; undo_valid = 1'b0;
        move_dir = 2'd0; load_board = '0;
        exp_score = 0;

        do_reset();

        // row0 = 1,1,1,1 left -> 2,2; score 8 from a fresh game
        do_load(64'h0000_0000_0000_1111);
        do_move(1);
        chk("t1_score", 64'(score), 64'd8);

        // no chain merge: 1,0,1,2 -> 2,2
        do_load(64'h0000_0000_0000_2101);
        do_move(1);

        // 15,15 saturates at 15
        do_load(64'h0000_0000_000F_000F);
        do_move(0);

        // unchanged board: no spawn, idle at T+5
        do_load(64'h0000_0000_0000_4321);
        do_move(1);

        // 10,10 right -> 11 at col3, won
        do_load(64'h0000_0000_0000_00AA);
        do_move(3);
        chk("t_won", {63'd0, won}, 64'd1);

        // checkerboard: game over, moves ignored
        cb = '0;
        for (int i = 0; i < 16; i++) cb[i*4 +: 4] = (((i / 4) + (i % 4)) % 2 == 1) ? 4'd2 : 4'd1;
        do_load(cb);
        chk("cb_over", {63'd0, game_over}, 64'd1);
        try_dropped_moves(cb);

        // undo behaviour
        b = 64'h0000_0000_0000_0011;
        pre_score = exp_score;
        do_load(b);
`ifdef GAME2048_UNDO_EN
        do_move(1);
        undo_valid = 1'b1;
        tick();
        undo_valid = 1'b0;
        wait_idle(10);
        chk("undo_board", board_state, b);
        chk("undo_score", 64'(score), 64'(pre_score));
        exp_score = pre_score;
        undo_valid = 1'b1;
        tick();
        undo_valid = 1'b0;
        chk("undo2_busy", {63'd0, busy}, 64'd0);
        tick();
        chk("undo2_board", board_state, b);
`else
        undo_valid = 1'b1;
        tick();
        undo_valid = 1'b0;
        chk("undo_busy", {63'd0, busy}, 64'd0);
        tick();
        chk("undo_board", board_state, b);
        chk("undo_score", 64'(score), 64'(pre_score));
        do_move(1);
`endif

        // randomized loads and moves
        for (int it = 0; it < 40; it++) begin
            do_load(rand_board());
            if (cur_go) try_dropped_moves(cur_board);
            else do_move(int'($urandom_range(0, 3)));
        end

        // score saturation with all-15 boards
        for (int k = 0; k < 3; k++) begin
            do_load(64'hFFFF_FFFF_FFFF_FFFF);
            do_move(1);
        end
        chk("sat_score", 64'(score), 64'hFFFFF);

        // reset in the middle of a move
        do_load(64'h0000_0000_0000_0011);
        move_dir = 2'd1;
        move_valid = 1'b1;
        tick();
        move_valid = 1'b0;
        tick();
        do_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
